// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_mem_pkg;

  localparam int ADDR_W_DEF       = 32;
  localparam int DATA_W_DEF       = 32;
  localparam int STARVE_LIMIT_DEF = 4;

  // Requester identifiers
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants issued while a fetch waits; flags when LIMIT is reached.
// Latency: count updates one edge after inc/clr; at_limit follows the registered count.
// Backpressure: none; clr has priority over inc, count holds at LIMIT.
module arb_starve_ctr #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  // clear on fetch grant, otherwise count up and stick at LIMIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               cnt <= '0;
    else if (clr)                          cnt <= '0;
    else if (inc && (cnt != W'(LIMIT)))    cnt <= cnt + 1'b1;
  end

  assign at_limit = (cnt == W'(LIMIT));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between IF (fetch) and MEM (LW/SW); data wins by default.
// Latency: accept-to-gnt is L+1 edges for memory latency L; accepts spaced at least L+2 cycles.
// Backpressure: requester holds req and sees stall until its one-cycle gnt; MEM_ARB_FAIRNESS_EN adds a fetch starvation guard.
module unified_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_gnt,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_gnt,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy
);

  state_t state, state_nxt;
  logic   accept;
  logic   complete;
  logic   sel;
  logic   force_if;

`ifdef MEM_ARB_FAIRNESS_EN
  logic starve_hit;

  arb_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .inc      (complete && (state == BUSY_D) && if_req),
    .clr      (complete && (state == BUSY_IF)),
    .at_limit (starve_hit)
  );

  // a starved fetch overrides data priority for one arbitration
  assign force_if = starve_hit && if_req;
`else
  assign force_if = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state: arbitrate only in IDLE, complete only on ack in BUSY_x, DONE always returns to IDLE
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    complete  = 1'b0;
    sel       = REQ_D;
    case (state)
      IDLE: begin
        if (d_req || if_req) begin
          accept    = 1'b1;
          sel       = (d_req && !force_if) ? REQ_D : REQ_IF;
          state_nxt = (sel == REQ_D) ? BUSY_D : BUSY_IF;
        end
      end
      BUSY_IF, BUSY_D: begin
        if (mem_ack) begin
          complete  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // memory port, grant pulses and read data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_gnt <= 1'b0;
      d_gnt  <= 1'b0;
      if (accept) begin
        mem_req <= 1'b1;
        if (sel == REQ_D) begin
          mem_we    <= d_we;
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
        end else begin
          mem_we    <= 1'b0;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
        end
      end
      if (complete) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        if (state == BUSY_IF) begin
          if_gnt   <= 1'b1;
          if_rdata <= mem_rdata;
        end else begin
          d_gnt <= 1'b1;
          if (!mem_we) d_rdata <= mem_rdata;
        end
      end
    end
  end

  assign busy     = (state != IDLE);
  assign if_stall = if_req && !if_gnt;
  assign d_stall  = d_req && !d_gnt;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter with a variable-latency memory model.
// Expected accesses are queued as stimulus is planned and popped as the memory port and grants fire.
// Build with or without MEM_ARB_FAIRNESS_EN; the starvation expectations follow the macro.
module tb_unified_mem_arbiter;
  import mips_mem_pkg::*;

  typedef struct {
    logic        id;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'hBADC0DE0;
  logic        if_gnt, if_stall, d_gnt, d_stall, mem_req, mem_we, busy;
  logic        mem_ack = 1'b0;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          mcnt = 0;
  logic        stray_ack = 1'b0;

  acc_t        exp_q[$];
  int          acc_cyc_q[$];
  logic [31:0] mem    [logic [31:0]];
  logic [31:0] shadow [logic [31:0]];
  logic [31:0] exp_d_rdata = '0;
  int          last_if_gnt_cyc = 0, last_d_gnt_cyc = 0;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_gnt(if_gnt), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_gnt(d_gnt), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'd3) ^ 32'h1357_9BDF;
  endfunction

  // plan one access in service order; expected read data comes from the shadow memory
  task automatic push_acc(input logic id, input logic we, input logic [31:0] a, input logic [31:0] wd);
    acc_t e;
    logic [31:0] cur;
    cur     = shadow.exists(a) ? shadow[a] : init_word(a);
    e.id    = id;
    e.we    = (id == REQ_D) ? we : 1'b0;
    e.addr  = a;
    e.wdata = (id == REQ_D) ? wd : 32'h0;
    e.rdata = cur;
    if (id == REQ_D) begin
      if (we) begin
        shadow[a] = wd;
        e.rdata   = exp_d_rdata;
      end else begin
        exp_d_rdata = cur;
      end
    end
    exp_q.push_back(e);
  endtask

  // memory model: ack L negedges after mem_req rises, so the DUT samples it L edges after accept
  always @(negedge clk) begin
    if (rst || !mem_req) begin
      mcnt      = 0;
      mem_ack   = stray_ack;
      mem_rdata = 32'hBADC0DE0;
    end else begin
      mcnt++;
      if (mcnt == lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : init_word(mem_addr);
        if (mem_we) mem[mem_addr] = mem_wdata;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'hBADC0DE0;
      end
    end
  end

  // scoreboard monitor
  logic mreq_q = 1'b0, inflight = 1'b0, gnt_prev = 1'b0;
  acc_t cur_acc;
  int   acc_cyc = 0;
  always @(negedge clk) begin
    if (rst) begin
      mreq_q   = 1'b0;
      inflight = 1'b0;
      gnt_prev = 1'b0;
    end else begin
      if (mem_req && !mreq_q) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_access", 1, 0);
        end else begin
          cur_acc = exp_q.pop_front();
          chk("acc_we", mem_we, cur_acc.we);
          chk("acc_addr", mem_addr, cur_acc.addr);
          chk("acc_wdata", mem_wdata, cur_acc.wdata);
          inflight = 1'b1;
          acc_cyc  = cyc;
          acc_cyc_q.push_back(cyc);
        end
      end
      mreq_q = mem_req;
      if (if_gnt || d_gnt) begin
        chk("gnt_pulse_width", gnt_prev, 0);
        chk("gnt_both", if_gnt && d_gnt, 0);
        if (!inflight) begin
          chk("unexpected_gnt", 1, 0);
        end else begin
          chk("gnt_id", d_gnt, cur_acc.id);
          chk("gnt_latency", cyc - acc_cyc, lat);
          if (cur_acc.id == REQ_IF) chk("if_rdata", if_rdata, cur_acc.rdata);
          else                      chk("d_rdata", d_rdata, cur_acc.rdata);
          inflight = 1'b0;
        end
        if (if_gnt) last_if_gnt_cyc = cyc;
        if (d_gnt)  last_d_gnt_cyc  = cyc;
      end
      gnt_prev = if_gnt || d_gnt;
      chk("if_stall", if_stall, if_req && !if_gnt);
      chk("d_stall", d_stall, d_req && !d_gnt);
    end
  end

  task automatic wait_if_gnt();
    int k = 0;
    do begin @(negedge clk); k++; end while (!if_gnt && k < 200);
    if (!if_gnt) chk("if_gnt_timeout", 0, 1);
  endtask

  task automatic wait_d_gnt();
    int k = 0;
    do begin @(negedge clk); k++; end while (!d_gnt && k < 200);
    if (!d_gnt) chk("d_gnt_timeout", 0, 1);
  endtask

  // fetch requester: holds if_req across n fetches, drops it after the last gnt cycle
  task automatic fetch_req(input logic [31:0] a, input int n);
    if_addr = a;
    if_req  = 1'b1;
    for (int k = 0; k < n; k++) wait_if_gnt();
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic data_acc(input logic we, input logic [31:0] a, input logic [31:0] wd);
    d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
    wait_d_gnt();
    @(posedge clk); #1;
    d_req = 1'b0; d_we = 1'b0;
  endtask

  // data requester keeping d_req high across n loads
  task automatic data_seq(input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      d_we = 1'b0; d_addr = base + 32'(4 * k); d_wdata = '0; d_req = 1'b1;
      wait_d_gnt();
      @(posedge clk); #1;
    end
    d_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", {mem_req, mem_we, if_gnt, d_gnt, busy}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // single fetch, L=1
    lat = 1;
    mem[32'h10] = 32'h8C010004; shadow[32'h10] = 32'h8C010004;
    push_acc(REQ_IF, 1'b0, 32'h10, 32'h0);
    fetch_req(32'h10, 1);
    repeat (3) @(negedge clk);
    chk("if_rdata_held", if_rdata, 32'h8C010004);

    // store then load, L=3
    lat = 3;
    push_acc(REQ_D, 1'b1, 32'h20, 32'hDEADBEEF);
    push_acc(REQ_D, 1'b0, 32'h20, 32'h0);
    data_acc(1'b1, 32'h20, 32'hDEADBEEF);
    chk("d_rdata_after_store", d_rdata, 32'h0);
    data_acc(1'b0, 32'h20, 32'h0);
    chk("d_rdata_after_load", d_rdata, 32'hDEADBEEF);

    // simultaneous requests, L=2: data first, fetch L+2 cycles later
    lat = 2;
    push_acc(REQ_D, 1'b0, 32'h30, 32'h0);
    push_acc(REQ_IF, 1'b0, 32'h34, 32'h0);
    fork
      data_acc(1'b0, 32'h30, 32'h0);
      fetch_req(32'h34, 1);
    join
    chk("simul_spacing", last_if_gnt_cyc - last_d_gnt_cyc, lat + 2);

    // req held through its gnt cycle: next accept only after DONE
    lat = 1;
    push_acc(REQ_IF, 1'b0, 32'h40, 32'h0);
    push_acc(REQ_IF, 1'b0, 32'h40, 32'h0);
    fetch_req(32'h40, 2);
    chk("done_hold_spacing", acc_cyc_q[acc_cyc_q.size()-1] - acc_cyc_q[acc_cyc_q.size()-2], lat + 2);

    // starvation: d_req held for six loads while a fetch waits
    lat = 1;
`ifdef MEM_ARB_FAIRNESS_EN
    for (int k = 0; k < 4; k++) push_acc(REQ_D, 1'b0, 32'h100 + 32'(4 * k), 32'h0);
    push_acc(REQ_IF, 1'b0, 32'h200, 32'h0);
    for (int k = 4; k < 6; k++) push_acc(REQ_D, 1'b0, 32'h100 + 32'(4 * k), 32'h0);
`else
    for (int k = 0; k < 6; k++) push_acc(REQ_D, 1'b0, 32'h100 + 32'(4 * k), 32'h0);
    push_acc(REQ_IF, 1'b0, 32'h200, 32'h0);
`endif
    fork
      data_seq(32'h100, 6);
      fetch_req(32'h200, 1);
    join
    repeat (2) @(negedge clk);
    chk("sb_drain", exp_q.size(), 0);

    // reset during BUSY_D with L=5, then a stray ack
    lat = 5;
    push_acc(REQ_D, 1'b0, 32'h80, 32'h0);
    @(posedge clk); #1;
    d_we = 1'b0; d_addr = 32'h80; d_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_mem_req", mem_req, 1);
    rst = 1'b1; d_req = 1'b0;
    exp_d_rdata = '0;
    #1;
    chk("rst_mid_mem_req", mem_req, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_d_rdata", d_rdata, 0);
    chk("rst_mid_if_rdata", if_rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stray_ack_no_gnt", {if_gnt, d_gnt, busy, mem_req}, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
